// File: rtl/sccb_seq_pkg.sv
// Shared types and constants for the SCCB register-initialisation sequencer.
// Holds the FSM state encoding, table entry markers and entry field slicing.
package sccb_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE_W,
    ST_WAIT_W,
    ST_RELEASE_W,
    ST_ISSUE_R,
    ST_WAIT_R,
    ST_RELEASE_R,
    ST_COMPARE,
    ST_DELAY,
    ST_NEXT,
    ST_FINISH,
    ST_FAIL
  } seq_state_t;

  localparam logic [15:0] SEQ_END   = 16'hFFFF;
  localparam logic [15:0] SEQ_DELAY = 16'hFFF0;

  localparam int SUB_MSB  = 15;
  localparam int SUB_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  function automatic logic [7:0] entry_sub(input logic [15:0] entry);
    return entry[SUB_MSB:SUB_LSB];
  endfunction

  function automatic logic [7:0] entry_data(input logic [15:0] entry);
    return entry[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Synchronous register table for camera bring-up, one cycle of read latency.
// Unlisted addresses read as the end-of-table marker.
module sccb_init_rom
  import sccb_seq_pkg::*;
#(
  parameter int TBL_AW = 8
) (
  input  logic              clk,
  input  logic [TBL_AW-1:0] addr,
  output logic [15:0]       data
);

  logic [15:0] rom_word;

  // Soft reset first, give the sensor time to settle, then program the defaults.
  always_comb begin
    rom_word = SEQ_END;
    case (addr)
      TBL_AW'(0): rom_word = 16'h1280;
      TBL_AW'(1): rom_word = SEQ_DELAY;
      TBL_AW'(2): rom_word = 16'h1101;
      TBL_AW'(3): rom_word = 16'h1204;
      TBL_AW'(4): rom_word = 16'h0C04;
      TBL_AW'(5): rom_word = 16'h3E19;
      TBL_AW'(6): rom_word = 16'h703A;
      TBL_AW'(7): rom_word = 16'h7135;
      default:    rom_word = SEQ_END;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= rom_word;
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks an external register table and drives the SCCB master's start/done
// handshake, with optional readback verification and bounded retry.
module sccb_init_sequencer
  import sccb_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h21,
  parameter int          TBL_AW         = 8,
  parameter logic [23:0] DELAY_CYCLES   = 24'd1_000_000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500_000,
  parameter int          MAX_RETRY      = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              verify_en,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [6:0]        sccb_ip_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data_in,
  input  logic [7:0]        sccb_data_out,
  input  logic              sccb_done,
  output logic              busy,
  output logic              init_done,
  output logic              error,
  output logic [TBL_AW-1:0] err_addr,
  output logic [7:0]        mismatch_cnt
);

  localparam logic [TBL_AW-1:0] TBL_LAST    = {TBL_AW{1'b1}};
  localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRY);
  // FAIL costs one more cycle, so trip one early to raise error exactly
  // TIMEOUT_CYCLES after start went high.
  localparam logic [19:0]       TMO_TRIP    = TIMEOUT_CYCLES - 20'd2;

  seq_state_t  state;
  logic        done_meta;
  logic        done_sync;
  logic        verify_q;
  logic [7:0]  rd_data;
  logic [7:0]  retry_cnt;
  logic [19:0] tmo_cnt;
  logic [23:0] dly_cnt;

  assign sccb_ip_addr = DEV_ADDR;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
    end else begin
      done_meta <= sccb_done;
      done_sync <= done_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      tbl_addr      <= '0;
      sccb_start    <= 1'b0;
      sccb_rw       <= 1'b0;
      sccb_sub_addr <= '0;
      sccb_data_in  <= '0;
      busy          <= 1'b0;
      init_done     <= 1'b0;
      error         <= 1'b0;
      err_addr      <= '0;
      mismatch_cnt  <= '0;
      verify_q      <= 1'b0;
      rd_data       <= '0;
      retry_cnt     <= '0;
      tmo_cnt       <= '0;
      dly_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            init_done    <= 1'b0;
            error        <= 1'b0;
            mismatch_cnt <= '0;
            retry_cnt    <= '0;
            tbl_addr     <= '0;
            verify_q     <= verify_en;
            busy         <= 1'b1;
            state        <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (tbl_data == SEQ_END) begin
            state <= ST_FINISH;
          end else if (tbl_data == SEQ_DELAY) begin
            dly_cnt <= DELAY_CYCLES - 24'd1;
            state   <= ST_DELAY;
          end else begin
            sccb_sub_addr <= entry_sub(tbl_data);
            sccb_data_in  <= entry_data(tbl_data);
            sccb_rw       <= 1'b0;
            state         <= ST_ISSUE_W;
          end
        end
        ST_ISSUE_W, ST_ISSUE_R: begin
          sccb_start <= 1'b1;
          tmo_cnt    <= '0;
          state      <= (state == ST_ISSUE_W) ? ST_WAIT_W : ST_WAIT_R;
        end
        ST_WAIT_W, ST_WAIT_R: begin
          if (done_sync) begin
            sccb_start <= 1'b0;
            if (state == ST_WAIT_R) begin
              rd_data <= sccb_data_out;
            end
            state <= (state == ST_WAIT_W) ? ST_RELEASE_W : ST_RELEASE_R;
          end else if (tmo_cnt >= TMO_TRIP) begin
            state <= ST_FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
          end
        end
        // Holding here until done drops guarantees the master has re-armed.
        ST_RELEASE_W: begin
          if (!done_sync) begin
            if (verify_q) begin
              sccb_rw <= 1'b1;
              state   <= ST_ISSUE_R;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_RELEASE_R: begin
          if (!done_sync) begin
            state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (rd_data == sccb_data_in) begin
            state <= ST_NEXT;
          end else begin
            if (mismatch_cnt != 8'hFF) begin
              mismatch_cnt <= mismatch_cnt + 8'd1;
            end
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + 8'd1;
              sccb_rw   <= 1'b0;
              state     <= ST_ISSUE_W;
            end else begin
              state <= ST_FAIL;
            end
          end
        end
        ST_DELAY: begin
          if (dly_cnt == '0) begin
            state <= ST_NEXT;
          end else begin
            dly_cnt <= dly_cnt - 24'd1;
          end
        end
        // The last table slot ends the pass instead of wrapping back to 0.
        ST_NEXT: begin
          retry_cnt <= '0;
          if (tbl_addr == TBL_LAST) begin
            state <= ST_FINISH;
          end else begin
            tbl_addr <= tbl_addr + TBL_AW'(1);
            state    <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          init_done <= 1'b1;
          busy      <= 1'b0;
          sccb_rw   <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_FAIL: begin
          error      <= 1'b1;
          busy       <= 1'b0;
          err_addr   <= tbl_addr;
          sccb_start <= 1'b0;
          sccb_rw    <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sccb_init_sequencer.md
# sccb_init_sequencer

Sequences camera-sensor register initialisation over the SCCB master core. Walks a register table of {sub_addr, data} entries and issues one 3-phase write per entry. When verify is enabled, each write is followed by a 2-phase-write/2-phase-read back; a mismatch triggers a bounded retry. Sits between the FreeRTOS-facing control registers (go/status) and the SCCB master's start/done handshake.

## Interface
- DEV_ADDR, 7'h21, 7-bit SCCB device ID driven on every transaction
- TBL_AW, 8, table address width (max 2^TBL_AW entries)
- DELAY_CYCLES, 24'd1_000_000, clk cycles waited on a delay entry
- TIMEOUT_CYCLES, 20'd500_000, max clk cycles from start assertion to done
- MAX_RETRY, 2, re-issues allowed per entry on readback mismatch
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- go  in  1  single-cycle pulse; starts a pass from entry 0; ignored while busy
- verify_en  in  1  sampled on go; 1 = read back every written entry
- tbl_addr  out  TBL_AW  table read address
- tbl_data  in  16  entry at tbl_addr, valid 1 cycle after tbl_addr changes; [15:8] sub_addr, [7:0] data
- sccb_start  out  1  level request to SCCB master
- sccb_rw  out  1  0 = 3-phase write, 1 = 2-phase write + 2-phase read
- sccb_ip_addr  out  7  = DEV_ADDR
- sccb_sub_addr  out  8  register address
- sccb_data_in  out  8  write data
- sccb_data_out  in  8  read data from master
- sccb_done  in  1  master completion level; asynchronous to clk phase, 2-FF synchronised internally
- busy  out  1  high from go to FINISH/FAIL exit
- init_done  out  1  sticky; pass completed without fatal error
- error  out  1  sticky; timeout or retries exhausted
- err_addr  out  TBL_AW  table index of the fatal entry
- mismatch_cnt  out  8  readback mismatches this pass, saturating at 8'hFF

## Operation
- Entry markers:
  - 16'hFFFF = end of table.
  - 16'hFFF0 = delay of DELAY_CYCLES; no SCCB traffic.
  - All other values are register writes.
- States:
  - IDLE, go: clear init_done, error, mismatch_cnt and retry count; tbl_addr = 0; go to FETCH.
  - FETCH: one wait cycle for table read latency; go to DECODE.
  - DECODE: dispatch on the entry.
    - 16'hFFFF goes to FINISH.
    - 16'hFFF0 goes to DELAY.
    - Otherwise latch sub_addr and data, set sccb_rw = 0, go to ISSUE_W.
  - ISSUE_W / ISSUE_R: assert sccb_start, clear the timeout counter, go to WAIT_W / WAIT_R.
  - WAIT_W / WAIT_R: stay until synchronised done = 1, then deassert sccb_start and go to RELEASE_W / RELEASE_R.
  - RELEASE_W: wait until synchronised done = 0.
    - If verify is on, set sccb_rw = 1 and go to ISSUE_R.
    - If verify is off, go to NEXT.
  - RELEASE_R: wait until synchronised done = 0, go to COMPARE. Read data is latched at done rise.
  - COMPARE: match goes to NEXT.
    - On mismatch: mismatch_cnt++ (saturating).
    - If retry < MAX_RETRY: retry++, go to ISSUE_W.
    - Otherwise go to FAIL.
  - DELAY: count DELAY_CYCLES-1 down to 0, then go to NEXT.
  - NEXT: tbl_addr++, retry = 0, go to FETCH.
    - If tbl_addr is already all-ones, go to FINISH. This is the wrap-around guard; no wrap to 0.
  - FINISH: set init_done, go to IDLE.
  - FAIL: set error, set err_addr = tbl_addr, deassert sccb_start, go to IDLE.
- Timeout: in any WAIT state, hitting TIMEOUT_CYCLES goes to FAIL regardless of retries.
- sccb_ip_addr, sccb_sub_addr and sccb_data_in are stable for the whole time sccb_start is high.
- go while busy is ignored. init_done and error are cleared only by the next accepted go, or by reset.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, except sccb_ip_addr = DEV_ADDR.
  - Counters 0.
- Reset mid-transaction: sccb_start drops asynchronously. The master sees start low and returns to its init state; no partial retry.
- Go to first sccb_start rise: 4 clk (go → FETCH → DECODE → ISSUE_W → start).
- Done-synchronisation latency: 2 clk.
- sccb_start falls 1 clk after synchronised done is seen. The next start waits for synchronised done low, which guarantees the master re-arms.
- busy falls the same cycle init_done or error rises.

## Structure
- Shared package sccb_seq_pkg holds:
  - the state enum;
  - entry markers SEQ_END = 16'hFFFF and SEQ_DELAY = 16'hFFF0;
  - the field slicing constants for sub_addr and data.
- Sub-module sccb_init_rom: synchronous 1-cycle-latency table ROM, parameterised by TBL_AW. The sequencer itself holds no table.

## Test plan
- 3-entry table {12'h80, 11'h01, FFFF}, verify off, master model with done after 100 clk:
  - exactly 2 write transactions carry sub_addr 12/data 80 and sub_addr 11/data 01;
  - init_done = 1, error = 0.
- Verify on, model returns the written value:
  - each entry gets one write then one read;
  - mismatch_cnt = 0.
- Verify on, model returns 8'h00 for sub_addr 12, MAX_RETRY = 2:
  - 3 writes issued;
  - error = 1, err_addr = 0, mismatch_cnt = 3.
- Delay entry FFF0 with DELAY_CYCLES = 50:
  - gap between the neighbouring transactions' done-fall and next start rise is ≥ 50 clk;
  - no start toggling in between.
- Model never raises done, TIMEOUT_CYCLES = 200:
  - error at start + 200 clk;
  - sccb_start low;
  - busy low.
- resetn pulsed low mid-WAIT_W:
  - sccb_start and all status outputs go 0 immediately;
  - a subsequent go restarts from tbl_addr = 0.
